// File: rtl/seq_priority_arbiter_pkg.sv
// Shared types and constants for the four-input sequential priority arbiter.
package seq_priority_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         IDX_W   = 2;
   localparam logic [1:0] IDX_TOP = 2'd3;
endpackage

// File: rtl/seq_priority_arbiter_if.sv
// Request/result handshake bundle between the compare bench and the arbiter.
interface seq_priority_arbiter_if
   import seq_priority_arbiter_pkg::*;
#(
   parameter int N = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in3;
   logic [N-1:0]     in2;
   logic [N-1:0]     in1;
   logic [N-1:0]     in0;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] grant;
   logic [N-1:0]     max_val;

   modport slave (
      input  in_valid, in3, in2, in1, in0, out_ready,
      output in_ready, out_valid, grant, max_val
   );

   modport master (
      output in_valid, in3, in2, in1, in0, out_ready,
      input  in_ready, out_valid, grant, max_val
   );
endinterface

// File: rtl/seq_priority_arbiter_pa_cmp_stage.sv
// Single compare step: a candidate replaces the running best only when strictly larger.
module pa_cmp_stage #(
   parameter int N  = 8,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_cand_val,
   input  logic [IW-1:0] i_cand_idx,
   input  logic [N-1:0]  i_best_val,
   input  logic [IW-1:0] i_best_idx,
   output logic [N-1:0]  o_best_val,
   output logic [IW-1:0] o_best_idx
);
   logic w_take;

   assign w_take     = (i_cand_val > i_best_val);
   assign o_best_val = w_take ? i_cand_val : i_best_val;
   assign o_best_idx = w_take ? i_cand_idx : i_best_idx;
endmodule

// File: rtl/seq_priority_arbiter.sv
// Four-input max-finder: captures a request set, scans indices 2..0 one per cycle
// against the seeded index-3 value, then holds the result until consumed.
module seq_priority_arbiter
   import seq_priority_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = IDX_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seq_priority_arbiter_if.slave bus
);
   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_cap [4];
   logic [N-1:0]  r_best_val;
   logic [IW-1:0] r_best_idx;
   logic [IW-1:0] r_cnt;

   logic          w_accept;
   logic [N-1:0]  w_cand_val;
   logic [N-1:0]  w_new_val;
   logic [IW-1:0] w_new_idx;

   assign bus.in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign w_cand_val   = r_cap[r_cnt];

   pa_cmp_stage #(
      .N  (N),
      .IW (IW)
   ) u_cmp (
      .i_cand_val (w_cand_val),
      .i_cand_idx (r_cnt),
      .i_best_val (r_best_val),
      .i_best_idx (r_best_idx),
      .o_best_val (w_new_val),
      .o_best_idx (w_new_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = IDLE;
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? SCAN : IDLE;
         SCAN:    w_state_nxt = (r_cnt == '0) ? DONE : SCAN;
         // Consuming a result and accepting the next set share one edge.
         DONE:    w_state_nxt = bus.out_ready ? (w_accept ? SCAN : IDLE) : DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) r_cap[k] <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_cap[3]   <= bus.in3;
         r_cap[2]   <= bus.in2;
         r_cap[1]   <= bus.in1;
         r_cap[0]   <= bus.in0;
         r_best_val <= bus.in3;
         r_best_idx <= IDX_TOP;
         r_cnt      <= IW'(2);
      end else if (r_state == SCAN) begin
         r_best_val <= w_new_val;
         r_best_idx <= w_new_idx;
         r_cnt      <= r_cnt - 1'b1;
      end
   end

   assign bus.out_valid = (r_state == DONE);
   assign bus.grant     = r_best_idx;
   assign bus.max_val   = r_best_val;
endmodule

// File: tb/tb_seq_priority_arbiter.sv
// Directed and randomized checks of seq_priority_arbiter against a max-with-tiebreak model.
module tb_seq_priority_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_priority_arbiter_if #(.N(8)) bus ();

   seq_priority_arbiter #(.N(8), .IW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: largest value, ties to the highest index (ascending scan with >=).
   task automatic ref_arb(input logic [7:0] a3, a2, a1, a0,
                          output logic [1:0] idx, output logic [7:0] val);
      logic [7:0] v [4];
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      idx = 2'd0;
      val = v[0];
      for (int i = 1; i < 4; i++) begin
         if (v[i] >= val) begin
            val = v[i];
            idx = 2'(i);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a3, a2, a1, a0);
      int k;
      k = 0;
      while (!bus.in_ready && k < 40) begin
         tick();
         k++;
      end
      if (!bus.in_ready) chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in3 = a3; bus.in2 = a2; bus.in1 = a1; bus.in0 = a0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in3 = 8'($urandom); bus.in2 = 8'($urandom);
      bus.in1 = 8'($urandom); bus.in0 = 8'($urandom);
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [7:0] a3, a2, a1, a0,
                            input logic [1:0] exp_g, input logic [7:0] exp_v);
      int cyc;
      send(a3, a2, a1, a0);
      wait_out(cyc);
      chk({tag, "_lat"}, 32'(cyc), 32'd3);
      chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_g));
      chk({tag, "_max"}, 32'(bus.max_val), 32'(exp_v));
      consume();
      chk({tag, "_vld_clr"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int         cyc, res_n, t0, t1;
      logic [1:0] g0, g1, eg;
      logic [7:0] ev, r3, r2, r1, r0;

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in3 = '0; bus.in2 = '0; bus.in1 = '0; bus.in0 = '0;
      g0 = '0; g1 = '0; t0 = 0; t1 = 0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_max", 32'(bus.max_val), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset during the scan abandons the operation.
      send(8'd10, 8'd20, 8'd30, 8'd40);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_grant", 32'(bus.grant), 32'd0);
      chk("midrst_max", 32'(bus.max_val), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("midrst_no_result", 32'(bus.out_valid), 32'd0);

      run_check("distinct", 8'h12, 8'h7F, 8'h30, 8'h05, 2'd2, 8'h7F);
      run_check("all_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd3, 8'hFF);
      run_check("all_zero", 8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 8'h00);
      run_check("tie_210", 8'h10, 8'h40, 8'h40, 8'h40, 2'd2, 8'h40);
      run_check("tie_10", 8'h01, 8'h02, 8'h09, 8'h09, 2'd1, 8'h09);

      // Backpressure: result must hold while out_ready is low.
      send(8'd1, 8'd2, 8'd3, 8'hC8);
      wait_out(cyc);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in3 = 8'($urandom); bus.in2 = 8'($urandom);
         bus.in1 = 8'($urandom); bus.in0 = 8'hFF;
         tick();
         chk("bp_vld", 32'(bus.out_valid), 32'd1);
         chk("bp_grant", 32'(bus.grant), 32'd0);
         chk("bp_max", 32'(bus.max_val), 32'hC8);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", 32'(bus.in_ready), 32'd1);
      tick();
      bus.out_ready = 1'b0;
      chk("bp_vld_clr", 32'(bus.out_valid), 32'd0);

      // Back-to-back with both handshakes held high.
      bus.out_ready = 1'b1;
      bus.in3 = 8'd5; bus.in2 = 8'd6; bus.in1 = 8'd7; bus.in0 = 8'd8;
      bus.in_valid = 1'b1;
      tick();
      bus.in3 = 8'd9; bus.in2 = 8'd3; bus.in1 = 8'd3; bus.in0 = 8'd3;
      res_n = 0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (res_n == 1 && c == t0 + 1) bus.in_valid = 1'b0;
         if (bus.out_valid && res_n < 2) begin
            if (res_n == 0) begin g0 = bus.grant; t0 = c; end
            else begin g1 = bus.grant; t1 = c; end
            res_n++;
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_count", 32'(res_n), 32'd2);
      chk("b2b_first_lat", 32'(t0), 32'd3);
      chk("b2b_grant0", 32'(g0), 32'd0);
      chk("b2b_grant1", 32'(g1), 32'd3);
      chk("b2b_spacing", 32'(t1 - t0), 32'd4);
      tick();

      // Randomized sets, some drawn from a narrow range to provoke ties.
      for (int n = 0; n < 100; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            r3 = 8'($urandom_range(3, 0)); r2 = 8'($urandom_range(3, 0));
            r1 = 8'($urandom_range(3, 0)); r0 = 8'($urandom_range(3, 0));
         end else begin
            r3 = 8'($urandom); r2 = 8'($urandom); r1 = 8'($urandom); r0 = 8'($urandom);
         end
         ref_arb(r3, r2, r1, r0, eg, ev);
         send(r3, r2, r1, r0);
         wait_out(cyc);
         for (int h = 0; h < int'($urandom_range(2, 0)); h++) tick();
         chk("rand_grant", 32'(bus.grant), 32'(eg));
         chk("rand_max", 32'(bus.max_val), 32'(ev));
         consume();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
